pll_clken_gen: RTL

Parametrised, fully synchronous clock-enable generator that derives NUM_CH independent fractional-rate enables and square-wave clocks from the single reference clock. It gives the fabric PLL-like output rates without consuming a hard PLL. Each channel is a phase accumulator with its own runtime-programmable increment and phase. A settle/lock FSM drives `locked` in the same way as the hard PLL wrapper, so downstream logic can sit behind either source unchanged.

---
 rtl/pll_clken_gen.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/pll_clken_gen.sv
// pll_clken_gen: fractional-rate clock-enable generator built from phase
// accumulators. A settle/lock FSM drives `locked` the same way the hard PLL
// wrapper does, so downstream logic can run from either source unchanged.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// S_RESET  | held in reset, config not accepted
// S_SETTLE | settle counter running 0..LOCK_CYCLES-1, config accepted
// S_LOCKED | outputs stable at the configured rates, config accepted
// S_APPLY  | one cycle: targeted channels load phase/inc from holding regs
module pll_clken_gen #(
  parameter int NUM_CH      = 4,
  parameter int ACC_W       = 16,
  parameter int DEFAULT_INC = 2 ** (ACC_W - 2),
  parameter int LOCK_CYCLES = 64,
  localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              refclk,
  input  logic              rst,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic              cfg_all,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [ACC_W-1:0]  cfg_inc,
  input  logic [ACC_W-1:0]  cfg_phase,
  output logic [NUM_CH-1:0] en_out,
  output logic [NUM_CH-1:0] clk_out,
  output logic              locked
);

  localparam int CNT_W = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOCK_CYCLES - 1);
  localparam logic [ACC_W-1:0] INC_RST  = ACC_W'(DEFAULT_INC);

  typedef enum logic [1:0] {
    S_RESET,
    S_SETTLE,
    S_LOCKED,
    S_APPLY
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             apply;
  logic             hs;

  logic             all_hold;
  logic [CH_W-1:0]  ch_hold;
  logic [ACC_W-1:0] inc_hold;
  logic [ACC_W-1:0] phase_hold;

  logic [ACC_W-1:0] acc [NUM_CH];
  logic [ACC_W-1:0] inc [NUM_CH];
  logic [NUM_CH-1:0] tgt;

  assign hs = cfg_valid & cfg_ready;

  // State and settle-counter register.
  always_ff @(posedge refclk) begin
    if (!rst) begin
      state <= S_RESET;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next-state, settle count and status outputs.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    cfg_ready = 1'b0;
    locked    = 1'b0;
    apply     = 1'b0;
    case (state)
      S_RESET: begin
        state_nxt = S_SETTLE;
        cnt_nxt   = '0;
      end
      S_SETTLE: begin
        cfg_ready = 1'b1;
        if (cfg_valid) begin
          state_nxt = S_APPLY;
          cnt_nxt   = '0;
        end else if (cnt == CNT_LAST) begin
          state_nxt = S_LOCKED;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      S_LOCKED: begin
        cfg_ready = 1'b1;
        locked    = 1'b1;
        if (cfg_valid) begin
          state_nxt = S_APPLY;
          cnt_nxt   = '0;
        end
      end
      S_APPLY: begin
        apply     = 1'b1;
        state_nxt = S_SETTLE;
        cnt_nxt   = '0;
      end
      default: state_nxt = S_RESET;
    endcase
  end

  // Capture the accepted request so the inputs may change during APPLY.
  always_ff @(posedge refclk) begin
    if (!rst) begin
      all_hold   <= 1'b0;
      ch_hold    <= '0;
      inc_hold   <= '0;
      phase_hold <= '0;
    end else if (hs) begin
      all_hold   <= cfg_all;
      ch_hold    <= cfg_ch;
      inc_hold   <= cfg_inc;
      phase_hold <= cfg_phase;
    end
  end

  // Channels reloaded in APPLY; an out-of-range cfg_ch matches no channel.
  always_comb begin
    tgt = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      tgt[c] = apply & (all_hold | (ch_hold == CH_W'(c)));
    end
  end

  // Phase accumulators; the carry out of each add is the registered enable.
  always_ff @(posedge refclk) begin
    for (int c = 0; c < NUM_CH; c++) begin
      if (!rst) begin
        acc[c]    <= '0;
        inc[c]    <= INC_RST;
        en_out[c] <= 1'b0;
      end else if (tgt[c]) begin
        acc[c]    <= phase_hold;
        inc[c]    <= inc_hold;
        en_out[c] <= 1'b0;
      end else begin
        {en_out[c], acc[c]} <= {1'b0, acc[c]} + {1'b0, inc[c]};
      end
    end
  end

  // Square-wave output is the accumulator MSB.
  always_comb begin
    clk_out = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      clk_out[c] = acc[c][ACC_W-1];
    end
  end

endmodule
